// File: rtl/player_pose_ctrl.sv
// Per-player pose/position sequencer for the fighter sprite renderer.
// Advances once per frame tick: walk, jump arc, timed attacks, latched death.
module player_pose_ctrl #(
    parameter int START_X       = 64,
    parameter int GROUND_Y      = 224,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 512,
    parameter int STEP          = 2,
    parameter int JUMP_V0       = 12,
    parameter int GRAVITY       = 1,
    parameter int PUNCH_FRAMES  = 12,
    parameter int KICK_FRAMES   = 16,
    parameter int CPUNCH_FRAMES = 12,
    parameter bit FLIP_INIT     = 1'b0
) (
    input  logic       vga_clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_punch,
    input  logic       btn_kick,
    input  logic       btn_block,
    input  logic       hp_zero,
    input  logic [9:0] opp_x,
    output logic       stand,
    output logic       crouch,
    output logic       jump,
    output logic       kick,
    output logic       punch,
    output logic       crouchpunch,
    output logic       move,
    output logic       block,
    output logic       dead,
    output logic       flip,
    output logic [9:0] spritex,
    output logic [9:0] spritey,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_WALK, S_CROUCH, S_JUMP, S_PUNCH,
        S_KICK, S_CPUNCH, S_BLOCK, S_DEAD
    } state_t;

    localparam logic [10:0] XMIN11  = 11'(X_MIN);
    localparam logic [10:0] XMAX11  = 11'(X_MAX);
    localparam logic [10:0] STEP11  = 11'(STEP);
    localparam logic [9:0]  START10 = 10'(START_X);
    localparam logic [9:0]  GND10   = 10'(GROUND_Y);
    localparam logic [7:0]  V0      = 8'(JUMP_V0);
    localparam logic [7:0]  GRAV8   = 8'(GRAVITY);
    localparam logic [7:0]  P_LD    = 8'(PUNCH_FRAMES - 1);
    localparam logic [7:0]  K_LD    = 8'(KICK_FRAMES - 1);
    localparam logic [7:0]  C_LD    = 8'(CPUNCH_FRAMES - 1);

    state_t             state;
    state_t             chain;
    logic [8:0]         pose;
    logic [7:0]         timer;
    logic signed [7:0]  vel;
    logic signed [10:0] height;
    logic signed [10:0] nh;
    logic [1:0]         jdir;
    logic [1:0]         walk_dir;
    logic               prev_punch;
    logic               prev_kick;
    logic               punch_press;
    logic               kick_press;
    logic               landing;
    logic               enter;

    // pose bit order: stand crouch jump kick punch cpunch move block dead
    function automatic logic [8:0] pose_of(input state_t s);
        logic [8:0] p;
        p = '0;
        unique case (s)
            S_IDLE:   p = 9'b100000000;
            S_WALK:   p = 9'b100000100;
            S_CROUCH: p = 9'b010000000;
            S_JUMP:   p = 9'b001000000;
            S_KICK:   p = 9'b000100000;
            S_PUNCH:  p = 9'b000010000;
            S_CPUNCH: p = 9'b000001000;
            S_BLOCK:  p = 9'b000000010;
            S_DEAD:   p = 9'b000000001;
            default:  p = 9'b100000000;
        endcase
        return p;
    endfunction

    function automatic logic is_locked(input state_t s);
        return (s == S_JUMP) || (s == S_PUNCH) ||
               (s == S_KICK) || (s == S_CPUNCH);
    endfunction

    // d = 2'b01 moves right, 2'b10 moves left; clamped before any wrap
    function automatic logic [9:0] step_x(input logic [9:0] x,
                                          input logic [1:0] d);
        logic [10:0] t;
        t = {1'b0, x};
        if (d == 2'b01) begin
            t = t + STEP11;
            if (t > XMAX11) t = XMAX11;
        end else if (d == 2'b10) begin
            if (t < XMIN11 + STEP11) t = XMIN11;
            else                     t = t - STEP11;
        end
        return t[9:0];
    endfunction

    always_comb begin
        punch_press = btn_punch & ~prev_punch;
        kick_press  = btn_kick & ~prev_kick;
        walk_dir    = {btn_left & ~btn_right, btn_right & ~btn_left};
        nh          = height + {{3{vel[7]}}, vel};
        landing     = (nh <= 11'sd0);
        chain       = S_IDLE;
        if (btn_block)                    chain = S_BLOCK;
        else if (kick_press)              chain = S_KICK;
        else if (punch_press && btn_down) chain = S_CPUNCH;
        else if (punch_press)             chain = S_PUNCH;
        else if (btn_up)                  chain = S_JUMP;
        else if (btn_down)                chain = S_CROUCH;
        else if (walk_dir != 2'b00)       chain = S_WALK;
        enter = 1'b0;
        unique case (state)
            S_DEAD:                  enter = 1'b0;
            S_JUMP:                  enter = landing;
            S_PUNCH, S_KICK, S_CPUNCH: enter = (timer == 8'd0);
            default:                 enter = 1'b1;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state      <= S_IDLE;
            pose       <= pose_of(S_IDLE);
            busy       <= 1'b0;
            spritex    <= START10;
            spritey    <= GND10;
            flip       <= FLIP_INIT;
            timer      <= '0;
            vel        <= '0;
            height     <= '0;
            jdir       <= 2'b00;
            prev_punch <= 1'b0;
            prev_kick  <= 1'b0;
        end else if (frame_tick) begin
            prev_punch <= btn_punch;
            prev_kick  <= btn_kick;
            if (hp_zero) begin
                state <= S_DEAD;
                pose  <= pose_of(S_DEAD);
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    S_DEAD: ;
                    S_JUMP: begin
                        if (!landing) begin
                            height  <= nh;
                            vel     <= vel - GRAV8;
                            spritex <= step_x(spritex, jdir);
                            spritey <= GND10 - nh[9:0];
                        end
                    end
                    S_PUNCH, S_KICK, S_CPUNCH: begin
                        if (timer != 8'd0) timer <= timer - 8'd1;
                    end
                    default: flip <= (opp_x < spritex);
                endcase
                if (enter) begin
                    state   <= chain;
                    pose    <= pose_of(chain);
                    busy    <= is_locked(chain);
                    height  <= '0;
                    spritey <= GND10;
                    unique case (chain)
                        S_JUMP: begin
                            vel  <= V0;
                            jdir <= walk_dir;
                        end
                        S_PUNCH:  timer <= P_LD;
                        S_KICK:   timer <= K_LD;
                        S_CPUNCH: timer <= C_LD;
                        S_WALK:   spritex <= step_x(spritex, walk_dir);
                        default: ;
                    endcase
                end
            end
        end
    end

    assign {stand, crouch, jump, kick, punch,
            crouchpunch, move, block, dead} = pose;

endmodule

// File: tb/tb_player_pose_ctrl.sv
// Bench for player_pose_ctrl: table of per-tick vectors plus
// hand-written walk, attack, jump, death and facing sequences.
module tb_player_pose_ctrl;

    logic       vga_clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_left = 1'b0, btn_right = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0;
    logic       btn_punch = 1'b0, btn_kick = 1'b0, btn_block = 1'b0;
    logic       hp_zero = 1'b0;
    logic [9:0] opp_x = 10'd300;
    logic       stand, crouch, jump, kick, punch;
    logic       crouchpunch, move, block, dead;
    logic       flip, busy;
    logic [9:0] spritex, spritey;

    player_pose_ctrl dut (
        .vga_clk(vga_clk), .Reset(Reset), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right),
        .btn_up(btn_up), .btn_down(btn_down),
        .btn_punch(btn_punch), .btn_kick(btn_kick),
        .btn_block(btn_block), .hp_zero(hp_zero), .opp_x(opp_x),
        .stand(stand), .crouch(crouch), .jump(jump), .kick(kick),
        .punch(punch), .crouchpunch(crouchpunch), .move(move),
        .block(block), .dead(dead), .flip(flip),
        .spritex(spritex), .spritey(spritey), .busy(busy)
    );

    always #5 vga_clk = ~vga_clk;

    localparam logic [8:0] F_STAND = 9'b100000000;
    localparam logic [8:0] F_CRCH  = 9'b010000000;
    localparam logic [8:0] F_JUMP  = 9'b001000000;
    localparam logic [8:0] F_KICK  = 9'b000100000;
    localparam logic [8:0] F_PNCH  = 9'b000010000;
    localparam logic [8:0] F_CP    = 9'b000001000;
    localparam logic [8:0] F_WALK  = 9'b100000100;
    localparam logic [8:0] F_BLCK  = 9'b000000010;
    localparam logic [8:0] F_DEAD  = 9'b000000001;

    // buttons: left right up down punch kick block
    localparam logic [6:0] B_0 = 7'b0000000;
    localparam logic [6:0] B_L = 7'b1000000;
    localparam logic [6:0] B_R = 7'b0100000;
    localparam logic [6:0] B_U = 7'b0010000;
    localparam logic [6:0] B_D = 7'b0001000;
    localparam logic [6:0] B_P = 7'b0000100;
    localparam logic [6:0] B_K = 7'b0000010;
    localparam logic [6:0] B_B = 7'b0000001;

    // m = {check flip, check x, check y}
    typedef struct {
        string      name;
        logic [6:0] b;
        logic [8:0] flags;
        logic       flp;
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] m;
    } vec_t;

    vec_t q[$];
    vec_t tbl[12];
    int   checks = 0;
    int   failures = 0;

    function automatic vec_t mk(string n, logic [6:0] b, logic [8:0] f,
                                logic fl, int x, int y, logic [2:0] m);
        vec_t v;
        v.name = n; v.b = b; v.flags = f; v.flp = fl;
        v.x = 10'(x); v.y = 10'(y); v.m = m;
        return v;
    endfunction

    task automatic chk(string n, logic [15:0] got, logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", n, got, exp);
        end
    endtask

    function automatic logic [8:0] pose_now();
        return {stand, crouch, jump, kick, punch,
                crouchpunch, move, block, dead};
    endfunction

    task automatic compare(vec_t v);
        logic exp_busy;
        exp_busy = |(v.flags & (F_JUMP | F_KICK | F_PNCH | F_CP));
        chk({v.name, ".pose"}, 16'(pose_now()), 16'(v.flags));
        chk({v.name, ".busy"}, 16'(busy), 16'(exp_busy));
        if (v.m[2]) chk({v.name, ".flip"}, 16'(flip), 16'(v.flp));
        if (v.m[1]) chk({v.name, ".x"}, 16'(spritex), 16'(v.x));
        if (v.m[0]) chk({v.name, ".y"}, 16'(spritey), 16'(v.y));
    endtask

    // one frame tick followed by an idle cycle to show outputs hold
    task automatic drive(logic [6:0] b);
        @(negedge vga_clk);
        {btn_left, btn_right, btn_up, btn_down,
         btn_punch, btn_kick, btn_block} = b;
        frame_tick = 1'b1;
        @(negedge vga_clk);
        frame_tick = 1'b0;
        @(negedge vga_clk);
    endtask

    task automatic step(vec_t v);
        q.push_back(v);
        drive(v.b);
        if (q.size() == 0) chk("sb_empty", 16'd1, 16'd0);
        else compare(q.pop_front());
    endtask

    task automatic do_reset();
        @(negedge vga_clk);
        Reset = 1'b1;
        frame_tick = 1'b1;
        {btn_left, btn_right, btn_up, btn_down,
         btn_punch, btn_kick, btn_block} = 7'b0100100;
        @(negedge vga_clk);
        Reset = 1'b0;
        frame_tick = 1'b0;
        {btn_left, btn_right, btn_up, btn_down,
         btn_punch, btn_kick, btn_block} = B_0;
        hp_zero = 1'b0;
        @(negedge vga_clk);
    endtask

    task automatic chk_reset(string n);
        chk({n, ".pose"}, 16'(pose_now()), 16'(F_STAND));
        chk({n, ".x"}, 16'(spritex), 16'd64);
        chk({n, ".y"}, 16'(spritey), 16'd224);
        chk({n, ".flip"}, 16'(flip), 16'd0);
        chk({n, ".busy"}, 16'(busy), 16'd0);
    endtask

    initial begin
        int ex;
        int ymin;
        tbl[0]  = mk("t_idle0", B_0,       F_STAND, 0, 64, 224, 3'b111);
        tbl[1]  = mk("t_idle1", B_0,       F_STAND, 0, 64, 224, 3'b111);
        tbl[2]  = mk("t_idle2", B_0,       F_STAND, 0, 64, 224, 3'b111);
        tbl[3]  = mk("t_right", B_R,       F_WALK,  0, 66, 224, 3'b111);
        tbl[4]  = mk("t_rght2", B_R,       F_WALK,  0, 68, 224, 3'b111);
        tbl[5]  = mk("t_left",  B_L,       F_WALK,  0, 66, 224, 3'b111);
        tbl[6]  = mk("t_lr",    B_L | B_R, F_STAND, 0, 66, 224, 3'b111);
        tbl[7]  = mk("t_down",  B_D,       F_CRCH,  0, 66, 224, 3'b111);
        tbl[8]  = mk("t_block", B_B,       F_BLCK,  0, 66, 224, 3'b111);
        tbl[9]  = mk("t_blk_k", B_B | B_K, F_BLCK,  0, 66, 224, 3'b111);
        tbl[10] = mk("t_k_eat", B_K,       F_STAND, 0, 66, 224, 3'b111);
        tbl[11] = mk("t_rel",   B_0,       F_STAND, 0, 66, 224, 3'b111);

        do_reset();
        chk_reset("reset");
        for (int i = 0; i < 12; i++) step(tbl[i]);

        // long walk right saturates at the right clamp
        do_reset();
        ex = 64;
        for (int i = 0; i < 300; i++) begin
            ex = (ex + 2 > 512) ? 512 : ex + 2;
            step(mk("walk_r", B_R, F_WALK, 0, ex, 224, 3'b011));
        end
        chk("walk_sat", 16'(spritex), 16'd512);

        // held punch fires once for 12 ticks
        do_reset();
        for (int k = 1; k <= 40; k++)
            step(mk("punch_hold", B_P, (k <= 12) ? F_PNCH : F_STAND,
                    0, 64, 224, 3'b011));
        step(mk("punch_rel", B_0, F_STAND, 0, 64, 224, 3'b011));
        step(mk("punch_again", B_P, F_PNCH, 0, 64, 224, 3'b011));

        // jump arc, punch held from the second tick is ignored
        do_reset();
        step(mk("jump_in", B_U, F_JUMP, 0, 64, 224, 3'b011));
        ymin = 1023;
        for (int k = 1; k <= 25; k++) begin
            step(mk("jump_arc", B_P, (k < 25) ? F_JUMP : F_STAND, 0,
                    64, (k == 12) ? 146 : 224,
                    (k == 12 || k == 25) ? 3'b011 : 3'b010));
            if (int'(spritey) < ymin) ymin = int'(spritey);
        end
        chk("jump_ymin", 16'(ymin), 16'd146);

        // crouch punch then kick interrupted by death
        do_reset();
        step(mk("crouch", B_D, F_CRCH, 0, 64, 224, 3'b011));
        step(mk("cp_in", B_D | B_P, F_CP, 0, 64, 224, 3'b011));
        for (int k = 2; k <= 12; k++)
            step(mk("cp_hold", B_D | B_P, F_CP, 0, 64, 224, 3'b011));
        step(mk("cp_out", B_D | B_P, F_CRCH, 0, 64, 224, 3'b011));
        step(mk("crouch2", B_D, F_CRCH, 0, 64, 224, 3'b011));
        step(mk("kick_in", B_D | B_K, F_KICK, 0, 64, 224, 3'b011));
        step(mk("kick_2", B_D | B_K, F_KICK, 0, 64, 224, 3'b011));
        hp_zero = 1'b1;
        step(mk("dead_in", B_D | B_K, F_DEAD, 0, 64, 224, 3'b111));
        hp_zero = 1'b0;
        step(mk("dead_up", B_U, F_DEAD, 0, 64, 224, 3'b111));
        step(mk("dead_r", B_R | B_P, F_DEAD, 0, 64, 224, 3'b111));
        step(mk("dead_k", B_K, F_DEAD, 0, 64, 224, 3'b111));
        do_reset();
        chk_reset("reset_dead");

        // death beats a simultaneous punch press
        hp_zero = 1'b1;
        step(mk("dead_vs_p", B_P, F_DEAD, 0, 64, 224, 3'b011));
        hp_zero = 1'b0;

        // facing follows opponent when free, frozen during a kick
        do_reset();
        opp_x = 10'd300;
        ex = 64;
        for (int i = 0; i < 68; i++) begin
            ex = ex + 2;
            step(mk("to_200", B_R, F_WALK, 0, ex, 224, 3'b110));
        end
        opp_x = 10'd100;
        step(mk("face_l", B_0, F_STAND, 1, 200, 224, 3'b110));
        step(mk("fk_in", B_K, F_KICK, 1, 200, 224, 3'b110));
        opp_x = 10'd400;
        for (int k = 2; k <= 16; k++)
            step(mk("fk_hold", B_K, F_KICK, 1, 200, 224, 3'b110));
        step(mk("fk_exit", B_K, F_STAND, 1, 200, 224, 3'b110));
        step(mk("face_r", B_0, F_STAND, 0, 200, 224, 3'b110));

        // reset mid-jump leaves no partial arc
        do_reset();
        step(mk("rj_in", B_U | B_R, F_JUMP, 0, 64, 224, 3'b011));
        for (int k = 1; k <= 5; k++)
            step(mk("rj_air", B_0, F_JUMP, 0, 64 + 2 * k, 0, 3'b010));
        do_reset();
        chk_reset("reset_jump");
        repeat (4) @(negedge vga_clk);
        chk_reset("hold_no_tick");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
